// File: rtl/iter_ctrl.sv
// Sequencing controller for the iterative Q1 datapath: load, init, then
// alternating compute/update phases until the iteration count or early stop.
module iter_ctrl #(
  parameter int unsigned N_ITER = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_cond,
  output logic             busy,
  output logic             done,
  output logic             ld_in,
  output logic             init,
  output logic             ld_acc,
  output logic             ld_q,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_CALC,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             r_busy;
  logic             r_done;
  logic             r_ld_in;
  logic             r_init;
  logic             r_ld_acc;
  logic             r_ld_q;

  // Last iteration is judged on the pre-increment count.
  assign w_last = (r_cnt == CNT_W'(N_ITER - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_INIT;
      S_INIT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_CALC;
      end
      S_CALC:   w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_state_nxt = (stop_cond || w_last) ? S_DONE : S_CALC;
      end
      S_DONE:   if (!start) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they track r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ld_in  <= 1'b0;
      r_init   <= 1'b0;
      r_ld_acc <= 1'b0;
      r_ld_q   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done   <= (w_state_nxt == S_DONE);
      r_ld_in  <= (w_state_nxt == S_LOAD);
      r_init   <= (w_state_nxt == S_INIT);
      r_ld_acc <= (w_state_nxt == S_CALC);
      r_ld_q   <= (w_state_nxt == S_UPDATE);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ld_in    = r_ld_in;
  assign init     = r_init;
  assign ld_acc   = r_ld_acc;
  assign ld_q     = r_ld_q;
  assign iter_cnt = r_cnt;

endmodule

// File: tb/tb_iter_ctrl.sv
// Bench for iter_ctrl: directed scenarios plus random start/stop/reset traffic,
// checked each cycle against a cycle-offset run model for N_ITER=8 and N_ITER=1.
module tb_iter_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop_cond;
  logic       busy8, done8, ld_in8, init8, ld_acc8, ld_q8;
  logic [3:0] cnt8;
  logic       busy1, done1, ld_in1, init1, ld_acc1, ld_q1;
  logic [3:0] cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: a run is a cycle offset k from the accepting edge plus a count.
  bit m_run  [2];
  bit m_done [2];
  int m_k    [2];
  int m_cnt  [2];

  iter_ctrl u_dut8 (
    .clk(clk), .rst(rst), .start(start), .stop_cond(stop_cond),
    .busy(busy8), .done(done8), .ld_in(ld_in8), .init(init8),
    .ld_acc(ld_acc8), .ld_q(ld_q8), .iter_cnt(cnt8)
  );

  iter_ctrl #(.N_ITER(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop_cond(stop_cond),
    .busy(busy1), .done(done1), .ld_in(ld_in1), .init(init1),
    .ld_acc(ld_acc1), .ld_q(ld_q1), .iter_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic int n_of(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  // Offsets: 0 load, 1 init, then even = compute, odd = update of iteration (k-3)/2.
  task automatic model_edge(input int i, input bit st, input bit sp, input bit r);
    if (r) begin
      m_run[i] = 0; m_done[i] = 0; m_k[i] = 0; m_cnt[i] = 0;
    end else if (m_run[i]) begin
      if (m_k[i] == 1) m_cnt[i] = 0;
      if (m_k[i] >= 3 && (m_k[i] % 2) == 1) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (sp || m_cnt[i] == n_of(i)) begin
          m_run[i] = 0; m_done[i] = 1;
        end else m_k[i] = m_k[i] + 1;
      end else m_k[i] = m_k[i] + 1;
    end else if (m_done[i]) begin
      if (!st) m_done[i] = 0;
    end else if (st) begin
      m_run[i] = 1; m_k[i] = 0;
    end
  endtask

  function automatic logic [9:0] exp_vec(input int i);
    bit run;
    int k;
    run = m_run[i];
    k   = m_k[i];
    return {run, m_done[i], run && k == 0, run && k == 1,
            run && k >= 2 && (k % 2) == 0, run && k >= 3 && (k % 2) == 1,
            4'(m_cnt[i])};
  endfunction

  // One clock: drive inputs, take the edge, update model, check both DUTs.
  task automatic step(input bit st, input bit sp, input bit r);
    start = st; stop_cond = sp; rst = r;
    @(posedge clk);
    model_edge(0, st, sp, r);
    model_edge(1, st, sp, r);
    #1;
    check("dut8", 32'({busy8, done8, ld_in8, init8, ld_acc8, ld_q8, cnt8}), 32'(exp_vec(0)));
    check("dut1", 32'({busy1, done1, ld_in1, init1, ld_acc1, ld_q1, cnt1}), 32'(exp_vec(1)));
  endtask

  int nq, na, nb, nd;

  initial begin
    start = 0; stop_cond = 0; rst = 1;
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_idle", 32'({busy8, done8, ld_in8, init8, ld_acc8, ld_q8, cnt8}), 32'd0);
    step(0, 0, 0);

    // Reset from the compute phase of iteration 3.
    step(1, 0, 0);
    for (int e = 1; e <= 8; e++) step(0, 0, 0);
    check("mid_acc", 32'(ld_acc8), 32'd1);
    check("mid_cnt", 32'(cnt8), 32'd3);
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_cnt", 32'(cnt8), 32'd0);
    step(0, 0, 0);

    // Full run with start held.
    nq = 0; na = 0; nb = 0;
    for (int e = 0; e <= 18; e++) begin
      step(1, 0, 0);
      nq += int'(ld_q8); na += int'(ld_acc8); nb += int'(busy8);
      if (e == 0) check("full_ldin_E0", 32'(ld_in8), 32'd1);
      if (e == 1) check("full_init_E1", 32'(init8), 32'd1);
      if (e == 17) check("full_notdone_E17", 32'(done8), 32'd0);
    end
    check("full_done_E18", 32'(done8), 32'd1);
    check("full_cnt", 32'(cnt8), 32'd8);
    check("full_ldq_pulses", 32'(nq), 32'd8);
    check("full_ldacc_pulses", 32'(na), 32'd8);
    check("full_busy_cycles", 32'(nb), 32'd18);
    step(1, 0, 0);
    step(1, 0, 0);
    check("full_done_held", 32'(done8), 32'd1);
    step(0, 0, 0);
    check("full_to_idle", 32'({busy8, done8}), 32'd0);
    check("full_cnt_hold", 32'(cnt8), 32'd8);

    // Early stop during the iteration-2 update, start pulsed once.
    nq = 0;
    for (int e = 0; e <= 9; e++) begin
      step(e == 0, e == 8, 0);
      nq += int'(ld_q8);
      if (e == 7) check("early_notdone_E7", 32'(done8), 32'd0);
      if (e == 8) begin
        check("early_done_E8", 32'(done8), 32'd1);
        check("early_cnt", 32'(cnt8), 32'd3);
      end
    end
    check("early_done_1cyc", 32'(done8), 32'd0);
    check("early_ldq_pulses", 32'(nq), 32'd3);

    // stop_cond high throughout: first update terminates.
    for (int e = 0; e <= 4; e++) step(e == 0, 1, 0);
    check("stop_done_E4", 32'(done8), 32'd1);
    check("stop_cnt", 32'(cnt8), 32'd1);
    step(0, 0, 0);

    // Start pulse only: done for one cycle after E18, no restart.
    nd = 0;
    for (int e = 0; e <= 25; e++) begin
      step(e == 0, 0, 0);
      nd += int'(done8);
      if (e == 18) check("pulse_done_E18", 32'(done8), 32'd1);
    end
    check("pulse_done_cycles", 32'(nd), 32'd1);
    check("pulse_no_restart", 32'(busy8), 32'd0);

    // Back-to-back runs on the single-iteration instance.
    for (int r = 0; r < 2; r++) begin
      for (int e = 0; e <= 4; e++) begin
        step(1, 0, 0);
        if (r == 1 && e == 2) check("b2b_cnt_cleared", 32'(cnt1), 32'd0);
      end
      check("b2b_done_E4", 32'(done1), 32'd1);
      check("b2b_cnt", 32'(cnt1), 32'd1);
      step(0, 0, 0);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(3, 0) != 0, $urandom_range(5, 0) == 0, $urandom_range(60, 0) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
